// File: rtl/lr_pkg.sv
// Shared types and default sizing for the linear-regressor sequencing controller.
package lr_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    ACCUM     = 4'd2,
    DRAIN_A   = 4'd3,
    COEF_GO   = 4'd4,
    COEF_WAIT = 4'd5,
    ERR       = 4'd6,
    DRAIN_E   = 4'd7,
    DONE      = 4'd8
  } lr_state_t;

  localparam int LR_N_SAMPLES = 150;
  localparam int LR_ADDR_W    = 8;
  localparam int LR_MEM_LAT   = 1;

endpackage

// File: rtl/lr_delay_line.sv
// Fixed-depth shift register that aligns issue strobes with downstream data latency.
module lr_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/lr_controller.sv
// Run sequencer: clear, accumulate pass, coefficient handshake, error pass, done.
module lr_controller
  import lr_pkg::*;
#(
  parameter int N_SAMPLES = LR_N_SAMPLES,
  parameter int ADDR_W    = LR_ADDR_W,
  parameter int MEM_LAT   = LR_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              coef_start,
  output logic              err_we,
  output logic [ADDR_W-1:0] err_addr,
  output logic              busy,
  output logic              ready
);

  localparam int DW = $clog2(MEM_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  lr_state_t         state_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [DW-1:0]     drain_cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              acc_clr_r;
  logic              coef_start_r;
  logic              busy_r;
  logic              ready_r;
  logic              acc_issue_r;
  logic              err_issue_r;
  logic [ADDR_W:0]   err_din_s;
  logic [ADDR_W:0]   err_dout_s;

  // Sequencer: state plus every registered strobe and address it drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_cnt_r   <= {ADDR_W{1'b0}};
      drain_cnt_r  <= {DW{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      acc_clr_r    <= 1'b0;
      coef_start_r <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b0;
      acc_issue_r  <= 1'b0;
      err_issue_r  <= 1'b0;
    end else begin
      acc_clr_r    <= 1'b0;
      coef_start_r <= 1'b0;
      acc_issue_r  <= 1'b0;
      err_issue_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= INIT;
            acc_clr_r <= 1'b1;
            busy_r    <= 1'b1;
            ready_r   <= 1'b0;
          end
        end
        INIT: begin
          state_r     <= ACCUM;
          addr_cnt_r  <= {ADDR_W{1'b0}};
          acc_issue_r <= 1'b1;
        end
        ACCUM: begin
          if (addr_cnt_r == LAST_ADDR) begin
            state_r     <= DRAIN_A;
            drain_cnt_r <= DW'(MEM_LAT - 1);
          end else begin
            addr_cnt_r  <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_addr_r  <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            acc_issue_r <= 1'b1;
          end
        end
        DRAIN_A: begin
          if (drain_cnt_r == {DW{1'b0}}) begin
            state_r      <= COEF_GO;
            coef_start_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - {{(DW-1){1'b0}}, 1'b1};
          end
        end
        COEF_GO: begin
          state_r <= COEF_WAIT;
        end
        COEF_WAIT: begin
          if (coef_done) begin
            state_r     <= ERR;
            addr_cnt_r  <= {ADDR_W{1'b0}};
            err_issue_r <= 1'b1;
          end
        end
        ERR: begin
          if (addr_cnt_r == LAST_ADDR) begin
            state_r     <= DRAIN_E;
            drain_cnt_r <= DW'(MEM_LAT);
          end else begin
            addr_cnt_r  <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_addr_r  <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            err_issue_r <= 1'b1;
          end
        end
        DRAIN_E: begin
          if (drain_cnt_r == {DW{1'b0}}) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - {{(DW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Accumulate-pass addresses are masked so the error index only ever carries error-pass addresses.
  assign err_din_s = {err_issue_r, mem_addr_r & {ADDR_W{err_issue_r}}};

  lr_delay_line #(.DEPTH(MEM_LAT), .WIDTH(1)) u_acc_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (acc_issue_r),
    .dout (acc_en)
  );

  lr_delay_line #(.DEPTH(MEM_LAT + 1), .WIDTH(ADDR_W + 1)) u_err_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (err_din_s),
    .dout (err_dout_s)
  );

  assign err_we     = err_dout_s[ADDR_W];
  assign err_addr   = err_dout_s[ADDR_W-1:0];
  assign mem_addr   = mem_addr_r;
  assign acc_clr    = acc_clr_r;
  assign coef_start = coef_start_r;
  assign busy       = busy_r;
  assign ready      = ready_r;

endmodule

// File: tb/tb_lr_controller.sv
// Directed bench: cycle-by-cycle vector table on a MEM_LAT=1 instance, pulse counting on MEM_LAT=2.
module tb_lr_controller;
  import lr_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start_a, coef_done_a, start_b, coef_done_b;
  logic [AW-1:0] mem_addr_a, err_addr_a, mem_addr_b, err_addr_b;
  logic acc_clr_a, acc_en_a, coef_start_a, err_we_a, busy_a, ready_a;
  logic acc_clr_b, acc_en_b, coef_start_b, err_we_b, busy_b, ready_b;

  always #5 clk = ~clk;

  lr_controller #(.N_SAMPLES(N), .ADDR_W(AW), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .coef_done(coef_done_a),
    .mem_addr(mem_addr_a), .acc_clr(acc_clr_a), .acc_en(acc_en_a),
    .coef_start(coef_start_a), .err_we(err_we_a), .err_addr(err_addr_a),
    .busy(busy_a), .ready(ready_a)
  );

  lr_controller #(.N_SAMPLES(N), .ADDR_W(AW), .MEM_LAT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .coef_done(coef_done_b),
    .mem_addr(mem_addr_b), .acc_clr(acc_clr_b), .acc_en(acc_en_b),
    .coef_start(coef_start_b), .err_we(err_we_b), .err_addr(err_addr_b),
    .busy(busy_b), .ready(ready_b)
  );

  logic [21:0] obs_a, obs_b;
  assign obs_a = {mem_addr_a, acc_clr_a, acc_en_a, coef_start_a, err_we_a, err_addr_a, busy_a, ready_a};
  assign obs_b = {mem_addr_b, acc_clr_b, acc_en_b, coef_start_b, err_we_b, err_addr_b, busy_b, ready_b};

  typedef struct {
    logic          cd;
    logic [AW-1:0] ma;
    logic          clr, en, cs, we;
    logic [AW-1:0] ea;
    logic          bsy, rdy;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [21:0] exp_of(vec_t v);
    return {v.ma, v.clr, v.en, v.cs, v.we, v.ea, v.bsy, v.rdy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cd, input int ma, input logic clr, input logic en,
                     input logic cs, input logic we, input int ea, input logic bsy, input logic rdy);
    vec_t v;
    v.cd = cd; v.ma = AW'(ma); v.clr = clr; v.en = en; v.cs = cs;
    v.we = we; v.ea = AW'(ea); v.bsy = bsy; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  // mode 0: plain run; 1: extra start in ACCUM and COEF_WAIT; 2: stray coef_done in ACCUM and COEF_GO
  task automatic run_table(input string tag, input int mode);
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start_a = 1'b0;
      check($sformatf("%s cycle %0d", tag, i + 1), 32'(obs_a), 32'(exp_of(tbl[i])));
      coef_done_a = tbl[i].cd;
      if (mode == 1 && (i + 1 == 3 || i + 1 == 9)) start_a = 1'b1;
      if (mode == 2 && (i + 1 == 4 || i + 1 == 7)) coef_done_a = 1'b1;
    end
    coef_done_a = 1'b0;
  endtask

  // Caller is at a negedge; start is sampled at the following edge (cycle 0 ends there).
  task automatic run_b(input string tag, output int n_en, output int n_we,
                       output int rdy_cyc, output int cs_cyc, output int bad_addr);
    n_en = 0; n_we = 0; rdy_cyc = -1; cs_cyc = -100; bad_addr = 0;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (cyc == 1) check({tag, " ready/busy after start"}, {30'd0, busy_b, ready_b}, 32'd2);
      if (coef_start_b) cs_cyc = cyc;
      coef_done_b = (cyc == cs_cyc + 3);
      if (acc_en_b) n_en++;
      if (err_we_b) begin
        if (err_addr_b != AW'(n_we)) bad_addr++;
        n_we++;
      end
      if (ready_b) begin
        rdy_cyc = cyc;
        break;
      end
    end
    coef_done_b = 1'b0;
  endtask

  initial begin
    int en1, we1, rc1, cs1, bad1, en2, we2, rc2, cs2, bad2, wcount;

    // N=4, MEM_LAT=1, coef_done driven in cycle 10 (three COEF_WAIT cycles)
    add(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 1  INIT
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 2  addr 0
    add(1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 3
    add(1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 4
    add(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 5
    add(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 6  DRAIN_A
    add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0); // 7  COEF_GO
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 8  COEF_WAIT
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 9
    add(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 10
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 11 ERR addr 0
    add(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0); // 12
    add(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0); // 13
    add(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0); // 14
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0); // 15 DRAIN_E
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0); // 16
    for (int i = 0; i < 4; i++) add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1); // 17..20 DONE

    rst = 1'b1; start_a = 1'b0; coef_done_a = 1'b0; start_b = 1'b0; coef_done_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("reset idle a %0d", i), 32'(obs_a), 32'd0);
      check($sformatf("reset idle b %0d", i), 32'(obs_b), 32'd0);
    end
    check("reset state", 32'(u_a.state_r), 32'(IDLE));

    run_table("nominal", 0);
    run_table("start while busy", 1);
    run_table("spurious coef_done", 2);

    // Abort during ERR once two error words have been written.
    @(negedge clk);
    start_a = 1'b1;
    wcount = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      coef_done_a = (c == 10);
      if (err_we_a) wcount++;
    end
    check("writes before abort", 32'(wcount), 32'd2);
    rst = 1'b1;
    for (int c = 15; c <= 24; c++) begin
      @(negedge clk);
      if (c == 16) rst = 1'b0;
      check($sformatf("quiet after abort %0d", c), 32'(obs_a), 32'd0);
    end
    run_table("fresh after abort", 0);

    // MEM_LAT=2: coef_start at N+2+L=8, ready at 2N+4+2L+W=19 with W=3.
    @(negedge clk);
    run_b("run1", en1, we1, rc1, cs1, bad1);
    check("b run1 acc_en count", 32'(en1), 32'd4);
    check("b run1 err_we count", 32'(we1), 32'd4);
    check("b run1 err_addr order", 32'(bad1), 32'd0);
    check("b run1 coef_start cycle", 32'(cs1), 32'd8);
    check("b run1 ready cycle", 32'(rc1), 32'd19);
    @(negedge clk);
    check("b ready held in DONE", {31'd0, ready_b}, 32'd1);
    run_b("run2", en2, we2, rc2, cs2, bad2);
    check("b run2 acc_en count", 32'(en2), 32'd4);
    check("b run2 err_we count", 32'(we2), 32'd4);
    check("b run2 err_addr order", 32'(bad2), 32'd0);
    check("b run2 ready cycle", 32'(rc2), 32'd19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
